imm_insn_encoder: RTL and testbench
===================================

IMM_INSN_ENCODER -- requirements
Module: imm_insn_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising-edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: in_valid  in  1  request valid; in_ready  out  1  request accepted when in_valid&&in_ready at clk edge.
REQ-004 SHALL have ports: in_imm  in  32  immediate value; in_fmt  in  2  format, 00 I, 01 S, 10 B, 11 J.
REQ-005 SHALL have ports: in_tmpl  in  32  instruction template, immediate bit positions ignored; in_li  in  1  load-immediate expansion mode; in_rd  in  5  destination register, LI mode only.
REQ-006 SHALL have ports: out_valid  out  1; out_ready  in  1; out_insn  out  32  encoded word; out_last  out  1  final word of request; out_err  out  1  immediate range error.

Function
REQ-007 Non-LI mode SHALL emit one word: template with its immediate positions replaced by in_imm scattered per RV32I format. Non-immediate template bits pass unchanged.
REQ-008 Scatter: I [31:20]=imm[11:0]; S [31:25]=imm[11:5], [11:7]=imm[4:0]; B [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; J [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
REQ-009 LI mode (in_fmt, in_tmpl ignored) SHALL emit ADDI rd,x0,imm as one word if imm is in [-2048,2047]. Otherwise it SHALL emit two words: LUI rd,hi then ADDI rd,rd,lo, with lo=sign-extended imm[11:0], hi=(imm+0x800)[31:12] modulo 2^32.
REQ-010 in_rd=0 in LI mode SHALL still emit the words unchanged; no suppression.
REQ-011 FSM states: IDLE (output slot empty or draining), HOLD1 (one word presented, none pending), HOLD2A (first of two presented, second pending), HOLD2B (second presented).
REQ-012 in_ready SHALL be 1 only when the state is IDLE, or when the state is HOLD1/HOLD2B and out_ready=1 (same-cycle replace). This gives full throughput for single-word requests.
REQ-013 Latency: an accepted word SHALL appear on out_valid the cycle after acceptance. The second LI word SHALL appear the cycle after the first is taken.
REQ-014 While out_valid=1 and out_ready=0, out_insn, out_last and out_err SHALL hold stable.
REQ-015 HOLD2A with out_ready=1 SHALL go to HOLD2B and load the ADDI word. HOLD1/HOLD2B with out_ready=1 and no new accept SHALL go to IDLE with out_valid=0.
REQ-016 out_last SHALL be 1 for single words and for the HOLD2B word, and 0 in HOLD2A.
REQ-017 in_valid deasserting without acceptance SHALL have no effect. A request is captured entirely at the acceptance edge.

Reset
REQ-018 rst_n low SHALL immediately force state IDLE and set out_valid=0, out_insn=0, out_last=0, out_err=0, with in_ready=1 after release.
REQ-019 Reset mid-request, including in HOLD2A, SHALL discard the pending second word. No word is emitted after reset release without a new acceptance.

Configuration
REQ-020 With IMM_RANGE_CHECK_EN defined, out_err SHALL be registered with the word. It is 1 when the immediate is out of range: I/S outside [-2048,2047]; B outside [-4096,4094] or imm[0]=1; J outside [-1048576,1048574] or imm[0]=1. It is always 0 in LI mode. The word is still emitted with the truncated bits.
REQ-021 Without IMM_RANGE_CHECK_EN, out_err SHALL be constant 0 and the range-check logic SHALL be absent.

Verification
REQ-022 I-format: imm=0xFFFFF800, tmpl=0x00000013, out_ready=1 -> next cycle out_insn=0x80000013, out_last=1, out_err=0.
REQ-023 B-format: imm=0xFFFFFFFC, tmpl=0x00000063 -> out_insn=0xFE000EE3, out_err=0.
REQ-024 LI: imm=0x12345FFF, rd=5 -> 0x123462B7 (out_last=0), then 0xFFF28293 (out_last=1); in_ready=0 while in HOLD2A.
REQ-025 LI small: imm=100, rd=5 -> single 0x06400293 with out_last=1. Back-to-back single-word requests with out_ready=1 -> one word per cycle.
REQ-026 With macro defined: J-format imm=0x00000003 -> out_err=1. B-format imm=0x00001000 -> out_err=1. Without macro the same stimulus gives out_err=0.
REQ-027 Backpressure/reset: LI split with out_ready=0 for 3 cycles -> out_insn stable at 0x123462B7. Assert rst_n low in HOLD2A -> out_valid=0 immediately, and the ADDI word never appears.

Source files
------------

// File: rtl/imm_insn_encoder.sv
// Immediate instruction encoder.
// Scatters a 32-bit immediate into an RV32I template (I/S/B/J formats), or expands a
// load-immediate into ADDI or a LUI+ADDI pair. Output is a registered valid/ready slot
// with a single pending word for the two-word expansion.
// Optional feature: define IMM_RANGE_CHECK_EN to register an immediate range error with
// each word; otherwise out_err is tied low and no range logic is built.
module imm_insn_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_imm,
  input  logic [1:0]  in_fmt,
  input  logic [31:0] in_tmpl,
  input  logic        in_li,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic        out_last,
  output logic        out_err
);

  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;

  typedef enum logic [1:0] {
    StIdle,   // output slot empty
    StHold1,  // single word presented
    StHold2A, // LUI presented, ADDI pending
    StHold2B  // ADDI presented
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] insn_q, insn_d;
  logic        last_q, last_d;
  logic [31:0] pend_q, pend_d;

  logic [31:0] imm_mask;
  logic [31:0] imm_bits;
  logic [31:0] fmt_word;
  logic        fits12;
  logic [19:0] li_hi;
  logic [31:0] li_addi_x0;
  logic [31:0] li_lui;
  logic [31:0] li_addi_rd;
  logic        two_word;
  logic [31:0] first_word;
  logic        accept;
  logic        load_new;

  // Immediate scatter positions and bits for the selected format.
  always_comb begin
    imm_mask = 32'h0;
    imm_bits = 32'h0;
    unique case (in_fmt)
      2'b00: begin
        imm_mask = 32'hFFF0_0000;
        imm_bits = {in_imm[11:0], 20'b0};
      end
      2'b01: begin
        imm_mask = 32'hFE00_0F80;
        imm_bits = {in_imm[11:5], 13'b0, in_imm[4:0], 7'b0};
      end
      2'b10: begin
        imm_mask = 32'hFE00_0F80;
        imm_bits = {in_imm[12], in_imm[10:5], 13'b0, in_imm[4:1], in_imm[11], 7'b0};
      end
      2'b11: begin
        imm_mask = 32'hFFFF_F000;
        imm_bits = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], 12'b0};
      end
      default: ;
    endcase
  end

  // Template merge and load-immediate expansion candidates.
  always_comb begin
    fmt_word   = (in_tmpl & ~imm_mask) | imm_bits;
    fits12     = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    // +0x800 compensates for the sign-extended low half added back by ADDI.
    li_hi      = 20'((in_imm + 32'h0000_0800) >> 12);
    li_addi_x0 = {in_imm[11:0], 5'd0, 3'b000, in_rd, OpcOpImm};
    li_lui     = {li_hi, in_rd, OpcLui};
    li_addi_rd = {in_imm[11:0], in_rd, 3'b000, in_rd, OpcOpImm};
    two_word   = in_li & ~fits12;
    if (!in_li) begin
      first_word = fmt_word;
    end else if (fits12) begin
      first_word = li_addi_x0;
    end else begin
      first_word = li_lui;
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic err_q, err_d;
  logic new_err;
  logic fits13;
  logic fits21;

  // Signed range check of the immediate for the selected format; LI never flags.
  always_comb begin
    fits13  = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    fits21  = (&in_imm[31:20]) | ~(|in_imm[31:20]);
    new_err = 1'b0;
    if (!in_li) begin
      unique case (in_fmt)
        2'b00, 2'b01: new_err = ~fits12;
        2'b10:        new_err = ~fits13 | in_imm[0];
        2'b11:        new_err = ~fits21 | in_imm[0];
        default:      new_err = 1'b0;
      endcase
    end
  end
`endif

  // Request acceptance: empty slot, or same-cycle replace of a final word.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StIdle:            in_ready = 1'b1;
      StHold1, StHold2B: in_ready = out_ready;
      StHold2A:          in_ready = 1'b0;
      default:           in_ready = 1'b0;
    endcase
    accept = in_valid & in_ready;
  end

  // Next-state and output-slot update.
  always_comb begin
    state_d  = state_q;
    insn_d   = insn_q;
    last_d   = last_q;
    pend_d   = pend_q;
    load_new = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        load_new = accept;
      end
      StHold1, StHold2B: begin
        if (out_ready) begin
          if (accept) begin
            load_new = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StHold2A: begin
        if (out_ready) begin
          state_d = StHold2B;
          insn_d  = pend_q;
          last_d  = 1'b1;
`ifdef IMM_RANGE_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
    if (load_new) begin
      state_d = two_word ? StHold2A : StHold1;
      insn_d  = first_word;
      last_d  = ~two_word;
      pend_d  = li_addi_rd;
`ifdef IMM_RANGE_CHECK_EN
      err_d   = new_err;
`endif
    end
  end

  // State and output registers; reset drops any pending second word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      insn_q  <= 32'h0;
      last_q  <= 1'b0;
      pend_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      insn_q  <= insn_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  // Error flag travels with its word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  assign out_valid = (state_q != StIdle);
  assign out_insn  = insn_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_imm_insn_encoder.sv
// Self-checking bench for imm_insn_encoder: directed cases plus randomized traffic
// against a queue-based reference model of the emitted word stream.
module tb_imm_insn_encoder;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit RangeCheck = 1'b1;
`else
  localparam bit RangeCheck = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_imm;
  logic [1:0]  in_fmt;
  logic [31:0] in_tmpl;
  logic        in_li;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic        out_last;
  logic        out_err;

  typedef struct packed {
    logic [31:0] insn;
    logic        last;
    logic        err;
  } word_t;

  word_t exp_q[$];
  int    n_checks;
  int    n_errors;

  imm_insn_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_fmt    (in_fmt),
    .in_tmpl   (in_tmpl),
    .in_li     (in_li),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_insn  (out_insn),
    .out_last  (out_last),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: words a request should produce, from the ISA field definitions.
  task automatic model(input logic [31:0] imm, input logic [1:0] fmt, input logic [31:0] tmpl,
                       input logic li, input logic [4:0] rd);
    int    simm;
    word_t w;
    logic [31:0] hi;
    logic [31:0] rd32;
    simm = $signed(imm);
    rd32 = 32'(rd);
    w.err = 1'b0;
    w.last = 1'b1;
    if (li) begin
      if (simm >= -2048 && simm <= 2047) begin
        w.insn = ((imm & 32'hFFF) << 20) | (rd32 << 7) | 32'h13;
        exp_q.push_back(w);
      end else begin
        hi = (imm + 32'h800) >> 12;
        w.insn = (hi << 12) | (rd32 << 7) | 32'h37;
        w.last = 1'b0;
        exp_q.push_back(w);
        w.insn = ((imm & 32'hFFF) << 20) | (rd32 << 15) | (rd32 << 7) | 32'h13;
        w.last = 1'b1;
        exp_q.push_back(w);
      end
    end else begin
      case (fmt)
        2'd0: begin
          w.insn = (tmpl & 32'h000F_FFFF) | ((imm & 32'hFFF) << 20);
          w.err  = (simm < -2048 || simm > 2047);
        end
        2'd1: begin
          w.insn = (tmpl & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
          w.err  = (simm < -2048 || simm > 2047);
        end
        2'd2: begin
          w.insn = (tmpl & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31)
                 | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                 | (((imm >> 11) & 32'h1) << 7);
          w.err  = (simm < -4096 || simm > 4094 || imm[0]);
        end
        default: begin
          w.insn = (tmpl & 32'h0000_0FFF) | (((imm >> 20) & 32'h1) << 31)
                 | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
                 | (((imm >> 12) & 32'hFF) << 12);
          w.err  = (simm < -1048576 || simm > 1048574 || imm[0]);
        end
      endcase
      w.err = w.err & RangeCheck;
      exp_q.push_back(w);
    end
  endtask

  // One clock: drive inputs at the falling edge, check, and update the model for the
  // handshakes that the next rising edge will complete.
  task automatic cycle(input logic v, input logic [31:0] imm, input logic [1:0] fmt,
                       input logic [31:0] tmpl, input logic li, input logic [4:0] rd,
                       input logic ordy);
    logic exp_ready;
    @(negedge clk);
    in_valid  = v;
    in_imm    = imm;
    in_fmt    = fmt;
    in_tmpl   = tmpl;
    in_li     = li;
    in_rd     = rd;
    out_ready = ordy;
    #1;
    exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
    check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
    check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (out_valid && exp_q.size() != 0) begin
      check_eq("out_insn", out_insn, exp_q[0].insn);
      check_eq("out_last", 32'(out_last), 32'(exp_q[0].last));
      check_eq("out_err", 32'(out_err), 32'(exp_q[0].err));
    end
    if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
    if (v && exp_ready) model(imm, fmt, tmpl, li, rd);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 32'h0, 2'd0, 32'h0, 1'b0, 5'd0, ordy);
  endtask

  logic [31:0] bnd [8];
  logic [31:0] r_imm;
  logic [31:0] held;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = 32'h0;
    in_fmt    = 2'd0;
    in_tmpl   = 32'h0;
    in_li     = 1'b0;
    in_rd     = 5'd0;
    out_ready = 1'b0;
    bnd = '{32'hFFFF_F800, 32'h0000_07FF, 32'h0000_0800, 32'hFFFF_F7FF,
            32'hFFFF_F000, 32'h0000_0FFE, 32'h000F_FFFE, 32'hFFF0_0000};

    #12;
    check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("rst_out_insn", out_insn, 32'h0);
    check_eq("rst_out_last", 32'(out_last), 32'h0);
    check_eq("rst_out_err", 32'(out_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'h1);

    // I-format negative boundary.
    cycle(1'b1, 32'hFFFF_F800, 2'd0, 32'h0000_0013, 1'b0, 5'd0, 1'b1);
    idle(1'b1);
    check_eq("i_fmt_insn", out_insn, 32'h8000_0013);
    check_eq("i_fmt_last", 32'(out_last), 32'h1);
    check_eq("i_fmt_err", 32'(out_err), 32'h0);

    // B-format -4.
    cycle(1'b1, 32'hFFFF_FFFC, 2'd2, 32'h0000_0063, 1'b0, 5'd0, 1'b1);
    idle(1'b1);
    check_eq("b_fmt_insn", out_insn, 32'hFE00_0EE3);
    check_eq("b_fmt_err", 32'(out_err), 32'h0);

    // LI split with 3 cycles of backpressure on the LUI word.
    cycle(1'b1, 32'h1234_5FFF, 2'd0, 32'h0, 1'b1, 5'd5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      check_eq("li_lui_insn", out_insn, 32'h1234_62B7);
      check_eq("li_lui_last", 32'(out_last), 32'h0);
      check_eq("li_hold2a_ready", 32'(in_ready), 32'h0);
    end
    idle(1'b1);
    idle(1'b1);
    check_eq("li_addi_insn", out_insn, 32'hFFF2_8293);
    check_eq("li_addi_last", 32'(out_last), 32'h1);
    idle(1'b1);

    // LI small, then back-to-back singles at full rate.
    cycle(1'b1, 32'd100, 2'd0, 32'h0, 1'b1, 5'd5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'(i * 3), 2'd0, 32'h0000_0013, 1'b0, 5'd0, 1'b1);
      check_eq("b2b_valid", 32'(out_valid), 32'h1);
      if (i == 0) check_eq("li_small_insn", out_insn, 32'h0640_0293);
    end
    idle(1'b1);
    idle(1'b1);

    // Range flags: misaligned J, out-of-range B.
    cycle(1'b1, 32'h0000_0003, 2'd3, 32'h0000_006F, 1'b0, 5'd0, 1'b1);
    idle(1'b1);
    check_eq("j_range_err", 32'(out_err), 32'(RangeCheck));
    cycle(1'b1, 32'h0000_1000, 2'd2, 32'h0000_0063, 1'b0, 5'd0, 1'b1);
    idle(1'b1);
    check_eq("b_range_err", 32'(out_err), 32'(RangeCheck));
    idle(1'b1);

    // Reset while the ADDI word is pending.
    cycle(1'b1, 32'h1234_5FFF, 2'd0, 32'h0, 1'b1, 5'd5, 1'b0);
    idle(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'h0);
    check_eq("midrst_out_insn", out_insn, 32'h0);
    check_eq("midrst_out_last", 32'(out_last), 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      r_imm = $urandom;
      case ($urandom_range(0, 4))
        0: r_imm = {{20{r_imm[11]}}, r_imm[11:0]};
        1: r_imm = {{19{r_imm[12]}}, r_imm[12:1], 1'b0};
        2: r_imm = bnd[$urandom_range(0, 7)];
        3: r_imm = {{11{r_imm[20]}}, r_imm[20:0]};
        default: ;
      endcase
      held = $urandom;
      cycle(($urandom_range(0, 3) != 0), r_imm, 2'($urandom_range(0, 3)), held,
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
